// File: rtl/sram_mem_ctrl.sv
// Multi-cycle data-memory controller: moves each CPU word as several wait-stated
// beats on a narrow asynchronous SRAM and freezes the pipeline via ready.
module sram_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int SRAM_DQ_W   = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DQ_W-1:0]   sram_dq_out,
    input  logic [SRAM_DQ_W-1:0]   sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    localparam int BEATS  = DATA_W / SRAM_DQ_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(WAIT_CYCLES);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   write_q, write_d;
    logic [SRAM_ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rbuf_q, rbuf_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [DATA_W-1:0]      rbufMerged;

    logic [SRAM_ADDR_W-1:0] sramAddr_q, sramAddr_d;
    logic [SRAM_DQ_W-1:0]   dqOut_q, dqOut_d;
    logic                   dqOe_q, dqOe_d;
    logic                   weN_q, weN_d;
    logic                   oeN_q, oeN_d;

    always_comb begin
        rbufMerged = rbuf_q;
        rbufMerged[int'(beat_q) * SRAM_DQ_W +: SRAM_DQ_W] = sram_dq_in;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (rd_en || wr_en) begin
                    state_d = ACCESS;
                    beat_d  = '0;
                    cnt_d   = '0;
                    write_d = wr_en;
                    base_d  = SRAM_ADDR_W'(((address - ADDR_W'(BASE_ADDR)) >> 2) * ADDR_W'(BEATS));
                    wdata_d = wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!write_q) begin
                        rbuf_d = rbufMerged;
                    end
                    if (beat_q == BEAT_LAST) begin
                        state_d = DONE;
                        if (!write_q) begin
                            rdata_d = rbufMerged;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM pins are registered from the next-state values so the strobes are glitch-free
    // yet still line up with the beat/cycle the FSM is in.
    always_comb begin
        sramAddr_d = sramAddr_q;
        dqOut_d    = dqOut_q;
        dqOe_d     = 1'b0;
        weN_d      = 1'b1;
        oeN_d      = 1'b1;
        if (state_d == ACCESS) begin
            sramAddr_d = base_d + SRAM_ADDR_W'(beat_d);
            if (write_d) begin
                dqOe_d  = 1'b1;
                dqOut_d = wdata_d[int'(beat_d) * SRAM_DQ_W +: SRAM_DQ_W];
                weN_d   = (cnt_d == CNT_LAST);
            end else begin
                oeN_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            rdata_q    <= '0;
            sramAddr_q <= '0;
            dqOut_q    <= '0;
            dqOe_q     <= 1'b0;
            weN_q      <= 1'b1;
            oeN_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            rdata_q    <= rdata_d;
            sramAddr_q <= sramAddr_d;
            dqOut_q    <= dqOut_d;
            dqOe_q     <= dqOe_d;
            weN_q      <= weN_d;
            oeN_q      <= oeN_d;
        end
    end

    assign ready       = (state_q == DONE) || ((state_q == IDLE) && !rd_en && !wr_en);
    assign rdata       = rdata_q;
    assign sram_addr   = sramAddr_q;
    assign sram_dq_out = dqOut_q;
    assign sram_dq_oe  = dqOe_q;
    assign sram_we_n   = weN_q;
    assign sram_oe_n   = oeN_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: default 16-bit/5-wait instance plus a
// 32-bit/2-wait instance, each with a small behavioural SRAM.
module tb_sram_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, rdA, wrA;
    logic [31:0] addrA, wdataA, rdataA;
    logic        readyA, dqOeA, weNA, oeNA;
    logic [17:0] sramAddrA;
    logic [15:0] dqOutA, dqInA;
    logic [15:0] memA [16];

    logic        rstB, rdB, wrB;
    logic [31:0] addrB, wdataB, rdataB;
    logic        readyB, dqOeB, weNB, oeNB;
    logic [17:0] sramAddrB;
    logic [31:0] dqOutB, dqInB;
    logic [31:0] memB [16];

    sram_mem_ctrl dutA (
        .clk(clk), .rst(rstA), .rd_en(rdA), .wr_en(wrA), .address(addrA), .wdata(wdataA),
        .rdata(rdataA), .ready(readyA), .sram_addr(sramAddrA), .sram_dq_out(dqOutA),
        .sram_dq_in(dqInA), .sram_dq_oe(dqOeA), .sram_we_n(weNA), .sram_oe_n(oeNA)
    );

    sram_mem_ctrl #(.SRAM_DQ_W(32), .WAIT_CYCLES(2)) dutB (
        .clk(clk), .rst(rstB), .rd_en(rdB), .wr_en(wrB), .address(addrB), .wdata(wdataB),
        .rdata(rdataB), .ready(readyB), .sram_addr(sramAddrB), .sram_dq_out(dqOutB),
        .sram_dq_in(dqInB), .sram_dq_oe(dqOeB), .sram_we_n(weNB), .sram_oe_n(oeNB)
    );

    assign dqInA = memA[sramAddrA[3:0]];
    assign dqInB = memB[sramAddrB[3:0]];

    always @(posedge clk) begin
        if (!weNA && dqOeA) memA[sramAddrA[3:0]] <= dqOutA;
        if (!weNB && dqOeB) memB[sramAddrB[3:0]] <= dqOutB;
    end

    typedef struct {
        bit          isWrite;
        logic [17:0] addr0;
        logic [31:0] data;
        logic [31:0] rdata;
    } exp_t;

    exp_t        qA[$];
    logic [31:0] qB[$];
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor A: gathers per-access strobe statistics and scores each completion.
    int          lowA = 0, weLowA = 0, oeLowA = 0, dqOeCycA = 0;
    logic [31:0] wordA = '0;
    logic [17:0] firstA = '0;
    logic [17:0] diffA;
    bit          haveFirstA = 0;
    bit          prevReadyA = 1;
    exp_t        eA;

    always @(negedge clk) begin
        if (!rstA) begin
            prevReadyA = 1; lowA = 0; weLowA = 0; oeLowA = 0; dqOeCycA = 0;
            haveFirstA = 0; wordA = '0;
        end else begin
            if (!readyA) lowA++;
            if (dqOeA) dqOeCycA++;
            if (!oeNA) oeLowA++;
            if (!weNA) begin
                weLowA++;
                if (!haveFirstA) begin
                    firstA = sramAddrA;
                    haveFirstA = 1;
                end
                diffA = sramAddrA - firstA;
                if (diffA == 18'd0) wordA[15:0] = dqOutA;
                else if (diffA == 18'd1) wordA[31:16] = dqOutA;
            end
            if (readyA && !prevReadyA) begin
                if (qA.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL A unexpected completion: got rdata %h expected no access", rdataA);
                end else begin
                    eA = qA.pop_front();
                    checkOutput("A rdata", rdataA, eA.rdata);
                    checkOutput("A ready low cycles", lowA, 32'd11);
                    checkOutput("A DONE strobes we/oe/dqoe", {weNA, oeNA, dqOeA}, 32'b110);
                    if (eA.isWrite) begin
                        checkOutput("A write first addr", firstA, eA.addr0);
                        checkOutput("A write word", wordA, eA.data);
                        checkOutput("A we_n low cycles", weLowA, 32'd8);
                        checkOutput("A dq_oe cycles", dqOeCycA, 32'd10);
                        checkOutput("A oe_n low on write", oeLowA, 32'd0);
                    end else begin
                        checkOutput("A oe_n low cycles", oeLowA, 32'd10);
                        checkOutput("A we_n low on read", weLowA, 32'd0);
                    end
                end
                lowA = 0; weLowA = 0; oeLowA = 0; dqOeCycA = 0; haveFirstA = 0; wordA = '0;
            end
            prevReadyA = readyA;
        end
    end

    // Monitor B: single-beat instance, scores read data and freeze length.
    int          lowB = 0;
    bit          prevReadyB = 1;
    logic [31:0] eB;

    always @(negedge clk) begin
        if (!rstB) begin
            prevReadyB = 1; lowB = 0;
        end else begin
            if (!readyB) lowB++;
            if (readyB && !prevReadyB) begin
                if (qB.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL B unexpected completion: got rdata %h expected no access", rdataB);
                end else begin
                    eB = qB.pop_front();
                    checkOutput("B rdata", rdataB, eB);
                    checkOutput("B ready low cycles", lowB, 32'd3);
                end
                lowB = 0;
            end
            prevReadyB = readyB;
        end
    end

    // Issues one request on instance A and waits (bounded) for its DONE cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input bit scramble);
        bit done;
        done = 0;
        rdA = rd; wrA = wr; addrA = addr; wdataA = data;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (scramble && i == 4) begin
                addrA = 32'd2000;
                wdataA = 32'h0;
            end
            if (readyA) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL A timeout: got no ready expected ready within 40 cycles");
        end
        @(posedge clk); #1;
        rdA = 0; wrA = 0;
    endtask

    task automatic waitDoneB(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (readyB) break;
        end
        if (!readyB) begin
            checks++; errors++;
            $display("[TB] FAIL B timeout: got no ready expected ready within 20 cycles");
        end
    endtask

    int gap;

    initial begin
        rstA = 0; rdA = 0; wrA = 0; addrA = 0; wdataA = 0;
        rstB = 0; rdB = 0; wrB = 0; addrB = 0; wdataB = 0;
        for (int i = 0; i < 16; i++) begin
            memA[i] = '0;
            memB[i] = '0;
        end
        memB[0] = 32'hCAFEF00D;
        memB[1] = 32'h12345678;
        repeat (2) @(posedge clk); #1;
        rstA = 1; rstB = 1;

        // Reset in the middle of a write
        wrA = 1; addrA = 32'd1024; wdataA = 32'hA5A55A5A;
        repeat (4) @(negedge clk);
        checkOutput("A we_n low mid-write", weNA, 32'd0);
        rstA = 0;
        #1;
        checkOutput("A reset we_n", weNA, 32'd1);
        checkOutput("A reset oe_n", oeNA, 32'd1);
        checkOutput("A reset dq_oe", dqOeA, 32'd0);
        checkOutput("A reset rdata", rdataA, 32'd0);
        checkOutput("A reset sram_addr", sramAddrA, 32'd0);
        wrA = 0;
        repeat (2) @(posedge clk); #1;
        rstA = 1;
        @(negedge clk);
        checkOutput("A idle ready", readyA, 32'd1);

        qA.push_back('{1'b1, 18'd0, 32'hDEADBEEF, 32'h0});
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);

        // Read back; rd_en is still high during DONE and must not retrigger
        qA.push_back('{1'b0, 18'd0, 32'h0, 32'hDEADBEEF});
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("A no restart ready", readyA, 32'd1);
        checkOutput("A no restart oe_n", oeNA, 32'd1);

        qA.push_back('{1'b1, 18'd2, 32'h0BADF00D, 32'hDEADBEEF});
        applyStimulus(1'b1, 1'b1, 32'd1028, 32'h0BADF00D, 1'b0);

        // Below BASE_ADDR wraps to the top of the SRAM
        qA.push_back('{1'b1, 18'h3FFFE, 32'h600DCAFE, 32'hDEADBEEF});
        applyStimulus(1'b0, 1'b1, 32'd1020, 32'h600DCAFE, 1'b0);
        qA.push_back('{1'b0, 18'h3FFFE, 32'h0, 32'h600DCAFE});
        applyStimulus(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);

        // Inputs changed mid-access must not reach the SRAM
        qA.push_back('{1'b1, 18'd4, 32'h13579BDF, 32'h600DCAFE});
        applyStimulus(1'b0, 1'b1, 32'd1032, 32'h13579BDF, 1'b1);
        qA.push_back('{1'b0, 18'd4, 32'h0, 32'h13579BDF});
        applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);

        // Reset during beat 1 of a read aborts it
        rdA = 1; addrA = 32'd1024;
        repeat (8) @(negedge clk);
        rstA = 0;
        #1;
        checkOutput("A abort rdata", rdataA, 32'd0);
        checkOutput("A abort oe_n", oeNA, 32'd1);
        rdA = 0;
        repeat (2) @(posedge clk); #1;
        rstA = 1;
        @(negedge clk);
        checkOutput("A abort ready", readyA, 32'd1);
        checkOutput("A abort rdata after", rdataA, 32'd0);

        // Single-beat instance: one read, then back-to-back reads
        qB.push_back(32'hCAFEF00D);
        rdB = 1; addrB = 32'd1024;
        waitDoneB(gap);
        @(posedge clk); #1;
        rdB = 0;
        @(negedge clk);
        qB.push_back(32'hCAFEF00D);
        qB.push_back(32'h12345678);
        @(posedge clk); #1;
        rdB = 1; addrB = 32'd1024;
        waitDoneB(gap);
        @(posedge clk); #1;
        addrB = 32'd1028;
        waitDoneB(gap);
        checkOutput("B back-to-back spacing", gap, 32'd4);
        @(posedge clk); #1;
        rdB = 0;

        repeat (3) @(negedge clk);
        checkOutput("A scoreboard drained", qA.size(), 32'd0);
        checkOutput("B scoreboard drained", qB.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
